// File: rtl/cache_pkg.sv
// Shared cache definitions: line geometry and the line-fill FSM encoding.
// Used by line_fill_ctrl and line_word_mux (and by the cache datapath).
package cache_pkg;
    localparam int WORD_BITS      = 32;
    localparam int WORDS_PER_LINE = 16;
    localparam int LINE_BITS      = 512;
    localparam int OFFSET_BITS    = 4;
    localparam int TAG_BITS       = WORD_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lf_state_e;
endpackage

// File: rtl/line_word_mux.sv
// Selects one word out of a cache line.
// Ports:
//   i_line   - full line, word i at bits [32i+31:32i]
//   i_offset - word offset within the line
//   o_word   - selected word (offset 15 -> bits [511:480])
module line_word_mux
    import cache_pkg::*;
(
    input  logic [LINE_BITS-1:0]   i_line,
    input  logic [OFFSET_BITS-1:0] i_offset,
    output logic [WORD_BITS-1:0]   o_word
);
    assign o_word = i_line[int'(i_offset) * WORD_BITS +: WORD_BITS];
endmodule

// File: rtl/line_fill_ctrl.sv
// Cache line-fill controller with a single-line buffer. Accepts one miss
// request at a time; on a buffer hit it answers immediately, otherwise it
// fetches the line from main memory (fixed MEM_LATENCY) and answers with
// the captured line and the requested word.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   req_valid/req_ready/req_addr     - miss request handshake (word address)
//   mem_addr/mem_req/mem_data        - main-memory fetch interface
//   fill_valid/fill_ready            - fill response handshake
//   fill_line/fill_addr/fill_word    - response payload
//   fill_err                         - only with LINE_FILL_CHECK_EN: captured
//                                      line failed the word == addr+i check
// Optional feature macro: LINE_FILL_CHECK_EN
module line_fill_ctrl
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [WORD_BITS-1:0] req_addr,
    output logic                 req_ready,
    output logic [WORD_BITS-1:0] mem_addr,
    output logic                 mem_req,
    input  logic [LINE_BITS-1:0] mem_data,
    output logic                 fill_valid,
    input  logic                 fill_ready,
    output logic [LINE_BITS-1:0] fill_line,
    output logic [WORD_BITS-1:0] fill_addr,
`ifdef LINE_FILL_CHECK_EN
    output logic                 fill_err,
`endif
    output logic [WORD_BITS-1:0] fill_word
);
    lf_state_e            r_state;
    lf_state_e            w_next_state;
    logic [WORD_BITS-1:0] r_mem_addr;
    logic                 r_mem_req;
    logic [3:0]           r_cnt;
    logic [LINE_BITS-1:0] r_line;
    logic [WORD_BITS-1:0] r_addr;
    logic [TAG_BITS-1:0]  r_tag;
    logic                 r_buf_vld;
    logic                 w_accept;
    logic                 w_hit;
    logic                 w_capture;
    logic                 w_line_bad;

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_hit     = r_buf_vld && (req_addr[WORD_BITS-1:OFFSET_BITS] == r_tag);
    assign w_capture = (r_state == WAIT) && (r_cnt == 4'd1);

`ifdef LINE_FILL_CHECK_EN
    logic [WORDS_PER_LINE-1:0] w_word_bad;
    logic                      r_fill_err;

    // Memory self-test pattern: word i of a line must equal line address + i.
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_chk
        assign w_word_bad[gi] =
            mem_data[gi*WORD_BITS +: WORD_BITS] != (r_mem_addr + WORD_BITS'(gi));
    end
    assign w_line_bad = |w_word_bad;
    assign fill_err   = r_fill_err;
`else
    assign w_line_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_next_state = w_hit ? RESP : WAIT;
            WAIT:    if (w_capture)  w_next_state = RESP;
            RESP:    if (fill_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr <= '0;
            r_mem_req  <= 1'b0;
            r_cnt      <= '0;
            r_line     <= '0;
            r_addr     <= '0;
            r_tag      <= '0;
            r_buf_vld  <= 1'b0;
`ifdef LINE_FILL_CHECK_EN
            r_fill_err <= 1'b0;
`endif
        end else begin
            r_mem_req <= 1'b0;
`ifdef LINE_FILL_CHECK_EN
            r_fill_err <= w_capture && w_line_bad;
`endif
            if (w_accept) begin
                r_addr <= req_addr;
                if (!w_hit) begin
                    r_mem_addr <= {req_addr[WORD_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    r_mem_req  <= 1'b1;
                    r_cnt      <= 4'(MEM_LATENCY);
                end
            end
            if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
                if (w_capture) begin
                    r_line    <= mem_data;
                    r_tag     <= r_addr[WORD_BITS-1:OFFSET_BITS];
                    // A line that failed the check is still returned but never reused.
                    r_buf_vld <= !w_line_bad;
                end
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign fill_valid = (r_state == RESP);
    assign mem_addr   = r_mem_addr;
    assign mem_req    = r_mem_req;
    assign fill_line  = r_line;
    assign fill_addr  = r_addr;

    line_word_mux u_word_mux (
        .i_line   (r_line),
        .i_offset (r_addr[OFFSET_BITS-1:0]),
        .o_word   (fill_word)
    );
endmodule

// File: tb/tb_line_fill_ctrl.sv
module tb_line_fill_ctrl;
    logic         clk = 1'b0;
    logic         rst_n      [2];
    logic         req_valid  [2];
    logic [31:0]  req_addr   [2];
    logic         req_ready  [2];
    logic [31:0]  mem_addr   [2];
    logic         mem_req    [2];
    logic [511:0] mem_data   [2];
    logic         fill_valid [2];
    logic         fill_ready [2];
    logic [511:0] fill_line  [2];
    logic [31:0]  fill_addr  [2];
    logic [31:0]  fill_word  [2];
`ifdef LINE_FILL_CHECK_EN
    logic         fill_err   [2];
`endif

    int checks = 0;
    int fails  = 0;
    bit corrupt = 1'b0;

    // reference state: buffer valid/tag, expected mem_addr, latency per instance
    bit          m_vld   [2];
    logic [27:0] m_tag   [2];
    logic [31:0] m_maddr [2];
    int          m_lat   [2];

    always #5 clk = ~clk;

    line_fill_ctrl #(.MEM_LATENCY(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
        .req_ready(req_ready[0]), .mem_addr(mem_addr[0]), .mem_req(mem_req[0]),
        .mem_data(mem_data[0]), .fill_valid(fill_valid[0]), .fill_ready(fill_ready[0]),
        .fill_line(fill_line[0]), .fill_addr(fill_addr[0]),
`ifdef LINE_FILL_CHECK_EN
        .fill_err(fill_err[0]),
`endif
        .fill_word(fill_word[0]));

    line_fill_ctrl #(.MEM_LATENCY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
        .req_ready(req_ready[1]), .mem_addr(mem_addr[1]), .mem_req(mem_req[1]),
        .mem_data(mem_data[1]), .fill_valid(fill_valid[1]), .fill_ready(fill_ready[1]),
        .fill_line(fill_line[1]), .fill_addr(fill_addr[1]),
`ifdef LINE_FILL_CHECK_EN
        .fill_err(fill_err[1]),
`endif
        .fill_word(fill_word[1]));

    // Memory contents: word i of the line at address A is A+i; optional
    // corruption of word 7 of line 0x40.
    function automatic logic [31:0] mem_word(input logic [31:0] base, input int i);
        logic [31:0] w;
        w = base + 32'(i);
        if (corrupt && base == 32'h40 && i == 7) w = w ^ 32'hDEAD0000;
        return w;
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            mem_data[d] = '0;
            for (int i = 0; i < 16; i++) mem_data[d][32*i +: 32] = mem_word(mem_addr[d], i);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the instance is idle; returns at the negedge
    // of the IDLE cycle following the response handshake.
    task automatic do_req(input int d, input logic [31:0] a, input int hold,
                          input bit keep, input logic [31:0] nxt);
        bit          hit, bad;
        int          n, got, nreq, explat;
        logic [31:0] base, w_exp, a_exp;
        hit    = m_vld[d] && (m_tag[d] == a[31:4]);
        base   = {a[31:4], 4'h0};
        bad    = corrupt && !hit && base == 32'h40;
        explat = hit ? 1 : m_lat[d] + 1;
        a_exp  = hit ? m_maddr[d] : base;
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        n = 0; got = 0; nreq = 0;
        while (got == 0 && n < 40) begin
            @(negedge clk);
            if (!keep) req_valid[d] = 1'b0;
            n++;
            if (mem_req[d]) nreq++;
            if (fill_valid[d]) got = n;
            if (!hit) chk("mem_addr_wait", mem_addr[d], base);
        end
        chk("fill_latency", 32'(got), 32'(explat));
        chk("mem_req_count", 32'(nreq), hit ? 32'd0 : 32'd1);
        chk("mem_addr", mem_addr[d], a_exp);
        m_maddr[d] = a_exp;
        chk("fill_addr", fill_addr[d], a);
        w_exp = mem_word(base, int'(a[3:0]));
        chk("fill_word", fill_word[d], w_exp);
        chk("fill_line_w0", fill_line[d][31:0], mem_word(base, 0));
        chk("fill_line_w15", fill_line[d][511:480], mem_word(base, 15));
`ifdef LINE_FILL_CHECK_EN
        chk("fill_err", 32'(fill_err[d]), 32'(bad));
`endif
        if (keep) req_addr[d] = nxt;
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 32'(fill_valid[d]), 32'd1);
            chk("hold_word", fill_word[d], w_exp);
            chk("hold_addr", fill_addr[d], a);
            chk("hold_ready", 32'(req_ready[d]), 32'd0);
            chk("hold_memreq", 32'(mem_req[d]), 32'd0);
            @(negedge clk);
        end
        fill_ready[d] = 1'b1;
        @(negedge clk);
        fill_ready[d] = 1'b0;
        chk("fill_valid_drop", 32'(fill_valid[d]), 32'd0);
        chk("req_ready_back", 32'(req_ready[d]), 32'd1);
        if (!hit) begin
            m_vld[d] = !bad;
            m_tag[d] = a[31:4];
        end
    endtask

    task automatic rand_reqs(input int d, input int cnt);
        logic [27:0] t;
        for (int k = 0; k < cnt; k++) begin
            t = ($urandom_range(0, 3) == 0) ? 28'($urandom) : 28'($urandom_range(1, 4));
            do_req(d, {t, 4'($urandom)}, int'($urandom_range(0, 3)), 1'b0, 32'h0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_addr[d] = '0; fill_ready[d] = 1'b0;
            m_vld[d] = 1'b0; m_tag[d] = '0; m_maddr[d] = '0;
        end
        m_lat[0] = 1; m_lat[1] = 3;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_mem_req", 32'(mem_req[0]), 32'd0);
        chk("rst_fill_valid", 32'(fill_valid[0]), 32'd0);
        chk("rst_mem_addr", mem_addr[0], 32'd0);
        chk("rst_fill_line", fill_line[0][31:0] | fill_line[0][511:480], 32'd0);
        chk("rst_fill_addr", fill_addr[0], 32'd0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);

        // miss, then hit in the same line
        do_req(0, 32'h13, 0, 1'b0, 32'h0);
        do_req(0, 32'h1A, 0, 1'b0, 32'h0);
        // response stalled 5 cycles with a new request pending behind it
        do_req(0, 32'h25, 5, 1'b1, 32'h2B);
        do_req(0, 32'h2B, 0, 1'b0, 32'h0);

        // reset in the middle of a fetch
        req_valid[0] = 1'b1; req_addr[0] = 32'h100;
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("wait_mem_req", 32'(mem_req[0]), 32'd1);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("arst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("arst_mem_req", 32'(mem_req[0]), 32'd0);
        chk("arst_mem_addr", mem_addr[0], 32'd0);
        chk("arst_fill_line", fill_line[0][31:0] | fill_line[0][511:480], 32'd0);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        m_vld[0] = 1'b0; m_maddr[0] = '0;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_valid", 32'(fill_valid[0]), 32'd0);
            @(negedge clk);
        end
        do_req(0, 32'h105, 0, 1'b0, 32'h0);
        // line 0x20 was buffered before reset; must refetch now
        do_req(0, 32'h21, 0, 1'b0, 32'h0);
        rand_reqs(0, 25);

        // longer memory latency
        do_req(1, 32'hFFFFFFFF, 1, 1'b0, 32'h0);
        do_req(1, 32'hFFFFFFF3, 0, 1'b0, 32'h0);
        rand_reqs(1, 10);

`ifdef LINE_FILL_CHECK_EN
        do_req(0, 32'h200, 0, 1'b0, 32'h0);
        corrupt = 1'b1;
        do_req(0, 32'h40, 1, 1'b0, 32'h0);
        corrupt = 1'b0;
        do_req(0, 32'h41, 0, 1'b0, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
